// File: rtl/stat_pkg.sv
// Shared types and default widths for the per-flow statistics block and its poller.
// No logic here; widths are also the defaults used by stat_pkt.
package stat_pkg;

  localparam int STAT_A_WIDTH = 3;
  localparam int STAT_D_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_PUSH
  } poll_state_t;

  typedef struct packed {
    logic [STAT_A_WIDTH-1:0] flow;
    logic [STAT_D_WIDTH-1:0] data;
    logic                    timeout;
    logic                    last;
  } stat_rec_t;

endpackage

// File: rtl/stat_poll_timer.sv
// Period trigger, one-deep pending sweep request and overrun pulse for stat_poller.
// trig_o is combinational on the wrap cycle; pend_o/overrun_o update one cycle after a request.
module stat_poll_timer #(
  parameter int PERIOD = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic auto_ena_i,
  input  logic start_i,
  input  logic idle_i,
  output logic trig_o,
  output logic pend_o,
  output logic overrun_o
);

  localparam int              PW     = $clog2(PERIOD);
  localparam logic [PW-1:0]   P_LAST = PW'(PERIOD - 1);

  logic [PW-1:0] cnt;
  logic          req;

  assign trig_o = auto_ena_i && (cnt == P_LAST);
  assign req    = start_i || trig_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt       <= '0;
      pend_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (!auto_ena_i || (cnt == P_LAST)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PW'(1);
      end

      overrun_o <= req && pend_o;

      // In IDLE the poller launches the sweep itself, so the request is consumed there.
      if (idle_i) begin
        pend_o <= 1'b0;
      end else if (req) begin
        pend_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stat_poller.sv
// Sweeps all flows of stat_pkt and emits one flow-tagged record per flow; 1 + L + 1 cycles per flow.
// Records are held in PUSH until out_rdy_i; no new read is issued while the output is stalled.
module stat_poller
  import stat_pkg::*;
#(
  parameter int A_WIDTH = STAT_A_WIDTH,
  parameter int D_WIDTH = STAT_D_WIDTH,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               auto_ena_i,
  output logic               rd_stb_o,
  output logic [A_WIDTH-1:0] rd_flow_num_o,
  input  logic [D_WIDTH-1:0] rd_data_i,
  input  logic               rd_data_val_i,
  output logic [D_WIDTH-1:0] out_data_o,
  output logic [A_WIDTH-1:0] out_flow_o,
  output logic               out_timeout_o,
  output logic               out_last_o,
  output logic               out_val_o,
  input  logic               out_rdy_i,
  output logic               busy_o,
  output logic               overrun_o
);

  localparam int                 TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]      TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [A_WIDTH-1:0] LAST_FLOW = '1;

  poll_state_t        state, state_n;
  logic [A_WIDTH-1:0] flow, flow_n;
  logic [TW-1:0]      tcnt, tcnt_n;
  logic [D_WIDTH-1:0] cap, cap_n;
  logic               to_flag, to_flag_n;
  logic               trig, pend, idle, push;

  assign idle = (state == ST_IDLE);
  assign push = (state == ST_PUSH);

  stat_poll_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .auto_ena_i (auto_ena_i),
    .start_i    (start_i),
    .idle_i     (idle),
    .trig_o     (trig),
    .pend_o     (pend),
    .overrun_o  (overrun_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      flow    <= '0;
      tcnt    <= '0;
      cap     <= '0;
      to_flag <= 1'b0;
    end else begin
      state   <= state_n;
      flow    <= flow_n;
      tcnt    <= tcnt_n;
      cap     <= cap_n;
      to_flag <= to_flag_n;
    end
  end

  always_comb begin
    state_n   = state;
    flow_n    = flow;
    tcnt_n    = tcnt;
    cap_n     = cap;
    to_flag_n = to_flag;
    case (state)
      ST_IDLE: begin
        flow_n = '0;
        if (start_i || trig || pend) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        tcnt_n  = '0;
        state_n = ST_WAIT;
      end
      // Responses are only accepted here, so a late one can never land on the next flow.
      ST_WAIT: begin
        if (rd_data_val_i) begin
          cap_n     = rd_data_i;
          to_flag_n = 1'b0;
          state_n   = ST_PUSH;
        end else if (tcnt == TO_LAST) begin
          cap_n     = '0;
          to_flag_n = 1'b1;
          state_n   = ST_PUSH;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      ST_PUSH: begin
        if (out_rdy_i) begin
          if (flow == LAST_FLOW) begin
            state_n = ST_IDLE;
          end else begin
            flow_n  = flow + A_WIDTH'(1);
            state_n = ST_REQ;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign rd_stb_o      = (state == ST_REQ);
  assign rd_flow_num_o = rd_stb_o ? flow : '0;
  assign busy_o        = !idle;

  assign out_val_o     = push;
  assign out_data_o    = push ? cap : '0;
  assign out_flow_o    = push ? flow : '0;
  assign out_timeout_o = push && to_flag;
  assign out_last_o    = push && (flow == LAST_FLOW);

endmodule

// File: tb/tb_stat_poller.sv
// Scoreboard bench for stat_poller with an L=2 stat_pkt model returning flow*16.
module tb_stat_poller;
  import stat_pkg::*;

  localparam int AW = STAT_A_WIDTH;
  localparam int DW = STAT_D_WIDTH;

  logic          clk           = 1'b0;
  logic          rst_i         = 1'b0;
  logic          start_i       = 1'b0;
  logic          auto_ena_i    = 1'b0;
  logic          out_rdy_i     = 1'b1;
  logic [DW-1:0] rd_data_i     = '0;
  logic          rd_data_val_i = 1'b0;
  logic          rd_stb_o;
  logic [AW-1:0] rd_flow_num_o;
  logic [DW-1:0] out_data_o;
  logic [AW-1:0] out_flow_o;
  logic          out_timeout_o, out_last_o, out_val_o, busy_o, overrun_o;

  int        checks   = 0;
  int        failures = 0;
  int        ovr_cnt  = 0;
  stat_rec_t exp_q[$];

  logic [7:0]    drop_mask   = '0;
  logic          late_inject = 1'b0;
  logic          v1 = 1'b0, v2 = 1'b0;
  logic [DW-1:0] d1 = '0, d2 = '0;

  stat_poller #(
    .A_WIDTH (AW),
    .D_WIDTH (DW),
    .PERIOD  (100),
    .TIMEOUT (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .auto_ena_i    (auto_ena_i),
    .rd_stb_o      (rd_stb_o),
    .rd_flow_num_o (rd_flow_num_o),
    .rd_data_i     (rd_data_i),
    .rd_data_val_i (rd_data_val_i),
    .out_data_o    (out_data_o),
    .out_flow_o    (out_flow_o),
    .out_timeout_o (out_timeout_o),
    .out_last_o    (out_last_o),
    .out_val_o     (out_val_o),
    .out_rdy_i     (out_rdy_i),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  // stat_pkt model: two negedge stages give a response two cycles after the strobe cycle.
  always @(negedge clk) begin
    rd_data_val_i = v2;
    rd_data_i     = d2;
    v2 = v1;
    d2 = d1;
    v1 = rd_stb_o && !drop_mask[rd_flow_num_o];
    d1 = DW'(rd_flow_num_o) << 4;
    if (late_inject && rd_stb_o && (rd_flow_num_o == 3'd6)) begin
      rd_data_val_i = 1'b1;
      rd_data_i     = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_i && out_val_o && out_rdy_i) begin
      stat_rec_t got, want;
      got = '{flow: out_flow_o, data: out_data_o, timeout: out_timeout_o, last: out_last_o};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got flow=%0d data=%0d to=%0b last=%0b required no record",
                 got.flow, got.data, got.timeout, got.last);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL sb_record got flow=%0d data=%0d to=%0b last=%0b required flow=%0d data=%0d to=%0b last=%0b",
                   got.flow, got.data, got.timeout, got.last, want.flow, want.data, want.timeout, want.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (overrun_o) ovr_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish required finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic push_rec(input int f, input int d, input logic to, input logic last);
    stat_rec_t r;
    r.flow    = AW'(f);
    r.data    = DW'(d);
    r.timeout = to;
    r.last    = last;
    exp_q.push_back(r);
  endtask

  task automatic push_sweep(input logic [7:0] drop);
    for (int f = 0; f < 8; f++) begin
      push_rec(f, drop[f] ? 0 : f * 16, drop[f], f == 7);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_stb(input logic [AW-1:0] f, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_stb_o && rd_flow_num_o == f) && n < budget);
    check($sformatf("stb_flow%0d_seen", f), rd_stb_o && (rd_flow_num_o == f), 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy_o, 1'b0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rd_stb_o, rd_flow_num_o, out_data_o, out_flow_o, out_timeout_o,
                            out_last_o, out_val_o, busy_o, overrun_o}, '0);
    rst_i = 1'b1;
    @(negedge clk);

    // Basic sweep
    push_sweep(8'h00);
    pulse_start();
    check("start_latency", {rd_stb_o, rd_flow_num_o}, {1'b1, 3'd0});
    repeat (31) @(negedge clk);
    check("busy_last_push", busy_o, 1'b1);
    check("last_flag_flow7", {out_last_o, out_flow_o}, {1'b1, 3'd7});
    @(negedge clk);
    check("busy_sweep_done", busy_o, 1'b0);
    repeat (15) @(negedge clk);
    check("busy_low_at_48", busy_o, 1'b0);

    // Backpressure on flow 3
    push_sweep(8'h00);
    pulse_start();
    n = 0;
    while (!(out_val_o && out_flow_o == 3'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_flow3", out_val_o && (out_flow_o == 3'd3), 1'b1);
    out_rdy_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {out_val_o, out_flow_o, out_data_o, out_timeout_o}, {1'b1, 3'd3, 32'd48, 1'b0});
      check("bp_no_stb", rd_stb_o, 1'b0);
    end
    out_rdy_i = 1'b1;
    @(negedge clk);
    check("bp_next_stb", {rd_stb_o, rd_flow_num_o}, {1'b1, 3'd4});
    wait_idle(100);

    // Timeout on flow 5, late response during flow 6 REQ
    drop_mask   = 8'h20;
    late_inject = 1'b1;
    push_sweep(8'h20);
    pulse_start();
    wait_stb(3'd5, 100, n);
    wait_stb(3'd6, 40, n);
    check("timeout_cost", n, 18);
    wait_idle(100);
    drop_mask   = 8'h00;
    late_inject = 1'b0;

    // Periodic trigger every 100 cycles
    auto_ena_i = 1'b1;
    push_sweep(8'h00);
    wait_stb(3'd0, 150, n);
    check("period_first", n, 100);
    push_sweep(8'h00);
    wait_stb(3'd0, 150, n);
    check("period_gap", n, 100);
    auto_ena_i = 1'b0;
    wait_idle(100);

    // Pending start, overrun, back-to-back sweep
    push_sweep(8'h00);
    push_sweep(8'h00);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    check("pend_no_overrun", overrun_o, 1'b0);
    repeat (3) @(negedge clk);
    pulse_start();
    check("overrun_pulse", overrun_o, 1'b1);
    @(negedge clk);
    check("overrun_one_cycle", overrun_o, 1'b0);
    wait_idle(100);
    @(negedge clk);
    check("b2b_restart", {rd_stb_o, rd_flow_num_o}, {1'b1, 3'd0});
    wait_idle(100);
    check("overrun_count", ovr_cnt, 1);

    // start_i coinciding with the timer wrap in IDLE
    auto_ena_i = 1'b1;
    push_sweep(8'h00);
    repeat (99) @(negedge clk);
    pulse_start();
    auto_ena_i = 1'b0;
    check("simul_stb", {rd_stb_o, rd_flow_num_o}, {1'b1, 3'd0});
    check("simul_no_overrun", overrun_o, 1'b0);
    wait_idle(100);
    repeat (5) @(negedge clk);
    check("simul_single_sweep", busy_o, 1'b0);
    check("simul_overrun_count", ovr_cnt, 1);

    // Reset during flow 2 WAIT
    push_rec(0, 0, 1'b0, 1'b0);
    push_rec(1, 16, 1'b0, 1'b0);
    pulse_start();
    wait_stb(3'd2, 50, n);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {rd_stb_o, rd_flow_num_o, out_data_o, out_flow_o, out_timeout_o,
                             out_last_o, out_val_o, busy_o, overrun_o}, '0);
    rst_i = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_quiet", {busy_o, out_val_o}, 2'b00);
    push_sweep(8'h00);
    pulse_start();
    check("midrst_restart_flow0", {rd_stb_o, rd_flow_num_o}, {1'b1, 3'd0});
    wait_idle(100);
    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
